// File: rtl/usb_rx_pkt.sv
// Packet-level USB receive stage: SYNC detect, LSB-first deserialization,
// PID check, CRC5/CRC16 validation and start/data/done reporting.
module usb_rx_pkt (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ll_sym,
   input  logic       ll_bit,
   input  logic       ll_valid,
   input  logic       ll_eop,
   input  logic       ll_sync,
   input  logic       ll_bs_skip,
   input  logic       ll_bs_err,
   output logic       pkt_start,
   output logic [3:0] pkt_pid,
   output logic [7:0] pkt_data,
   output logic       pkt_data_stb,
   output logic       pkt_done_ok,
   output logic       pkt_done_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PID  = 2'd1,
      S_DATA = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   // Good residuals expressed in the reflected (LSB-out) register order.
   localparam logic [4:0]  CRC5_RES  = 5'b00110;
   localparam logic [15:0] CRC16_RES = 16'hB001;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [6:0]  sh_q, sh_d;
   logic [4:0]  crc5_q, crc5_d;
   logic [15:0] crc16_q, crc16_d;
   logic        start_q, start_d;
   logic [3:0]  pid_q, pid_d;
   logic [7:0]  data_q, data_d;
   logic        stb_q, stb_d;
   logic        ok_q, ok_d;
   logic        err_q, err_d;

   logic        acc_bit;
   logic        byte_done;
   logic [7:0]  byte_new;

   function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
      logic fb;
      fb = c[0] ^ b;
      crc5_step = {1'b0, c[4:1]} ^ (fb ? 5'b10100 : 5'b00000);
   endfunction

   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[0] ^ b;
      crc16_step = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
   endfunction

   // Length and CRC rule for the packet class selected by the latched PID.
   function automatic logic class_ok(input logic [3:0]  pid,
                                     input logic [1:0]  nbytes,
                                     input logic [4:0]  c5,
                                     input logic [15:0] c16);
      logic r;
      r = 1'b0;
      if (pid[1:0] == 2'b01 || pid == 4'b0100)
         r = (nbytes == 2'd2) && (c5 == CRC5_RES);
      else if (pid[1:0] == 2'b11)
         r = (nbytes >= 2'd2) && (c16 == CRC16_RES);
      else if (pid[1:0] == 2'b10 || pid == 4'b1100)
         r = (nbytes == 2'd0);
      return r;
   endfunction

   assign acc_bit   = ll_valid & ~ll_bs_skip & (ll_sym[1] ^ ll_sym[0]);
   assign byte_new  = {ll_bit, sh_q};
   assign byte_done = acc_bit & (bit_cnt_q == 3'd7);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      sh_d       = sh_q;
      crc5_d     = crc5_q;
      crc16_d    = crc16_q;
      start_d    = 1'b0;
      pid_d      = pid_q;
      data_d     = data_q;
      stb_d      = 1'b0;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ll_valid & ll_sync) begin
               state_d    = S_PID;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 2'd0;
               crc5_d     = 5'h1F;
               crc16_d    = 16'hFFFF;
            end
         end
         S_PID: begin
            if (ll_valid & (ll_bs_err | ll_eop)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (acc_bit) begin
               sh_d      = byte_new[7:1];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (byte_done) begin
                  if (byte_new[3:0] == ~byte_new[7:4]) begin
                     pid_d   = byte_new[3:0];
                     start_d = 1'b1;
                     state_d = S_DATA;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end
               end
            end
         end
         S_DATA: begin
            if (ll_valid & ll_bs_err) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (ll_valid & ll_eop) begin
               if (bit_cnt_q == 3'd0 && class_ok(pid_q, byte_cnt_q, crc5_q, crc16_q))
                  ok_d = 1'b1;
               else
                  err_d = 1'b1;
               state_d = S_IDLE;
            end else if (acc_bit) begin
               sh_d      = byte_new[7:1];
               bit_cnt_d = bit_cnt_q + 3'd1;
               crc5_d    = crc5_step(crc5_q, ll_bit);
               crc16_d   = crc16_step(crc16_q, ll_bit);
               if (byte_done) begin
                  data_d     = byte_new;
                  stb_d      = 1'b1;
                  byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
               end
            end
         end
         S_ERR: begin
            // Error already reported on entry; just wait for the line to settle.
            if (ll_valid & (ll_eop | ll_bs_err))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 2'd0;
         start_q    <= 1'b0;
         pid_q      <= 4'd0;
         data_q     <= 8'd0;
         stb_q      <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         start_q    <= start_d;
         pid_q      <= pid_d;
         data_q     <= data_d;
         stb_q      <= stb_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
      end
   end

   // Shift and CRC registers are always initialised before use, so no reset.
   always_ff @(posedge clk) begin
      sh_q    <= sh_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
   end

   assign pkt_start    = start_q;
   assign pkt_pid      = pid_q;
   assign pkt_data     = data_q;
   assign pkt_data_stb = stb_q;
   assign pkt_done_ok  = ok_q;
   assign pkt_done_err = err_q;

endmodule

// File: tb/tb_usb_rx_pkt.sv
// Directed bench for usb_rx_pkt: table of packets with expected pulse counts,
// plus hand sequences for reset, output latency and asynchronous reset.
module tb_usb_rx_pkt;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] ll_sym = 2'b10;
   logic       ll_bit = 1'b0;
   logic       ll_valid = 1'b0;
   logic       ll_eop = 1'b0;
   logic       ll_sync = 1'b0;
   logic       ll_bs_skip = 1'b0;
   logic       ll_bs_err = 1'b0;
   logic       pkt_start;
   logic [3:0] pkt_pid;
   logic [7:0] pkt_data;
   logic       pkt_data_stb;
   logic       pkt_done_ok;
   logic       pkt_done_err;

   usb_rx_pkt dut (
      .clk(clk), .rst(rst), .ll_sym(ll_sym), .ll_bit(ll_bit), .ll_valid(ll_valid),
      .ll_eop(ll_eop), .ll_sync(ll_sync), .ll_bs_skip(ll_bs_skip), .ll_bs_err(ll_bs_err),
      .pkt_start(pkt_start), .pkt_pid(pkt_pid), .pkt_data(pkt_data),
      .pkt_data_stb(pkt_data_stb), .pkt_done_ok(pkt_done_ok), .pkt_done_err(pkt_done_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_start = 0, n_stb = 0, n_ok = 0, n_err = 0;

   always @(negedge clk) begin
      if (pkt_start)    n_start++;
      if (pkt_data_stb) n_stb++;
      if (pkt_done_ok)  n_ok++;
      if (pkt_done_err) n_err++;
   end

   typedef struct {
      logic [7:0] b [4];
      int         nb;
      int         extra;
      int         skip;
      int         bserr;
      int         exp_start;
      int         exp_pid;
      int         exp_stb;
      int         exp_ok;
      int         exp_err;
      int         exp_data;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input int nb, input int extra, input int skip, input int bserr,
                               input int es, input int ep, input int estb,
                               input int eok, input int eerr, input int edata);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.nb = nb; v.extra = extra; v.skip = skip; v.bserr = bserr;
      v.exp_start = es; v.exp_pid = ep; v.exp_stb = estb;
      v.exp_ok = eok; v.exp_err = eerr; v.exp_data = edata;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic e,
                        input logic sy, input logic sk, input logic be);
      @(negedge clk);
      ll_valid = v; ll_sym = s; ll_bit = b; ll_eop = e;
      ll_sync = sy; ll_bs_skip = sk; ll_bs_err = be;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_bit(input logic b);
      drive(1'b1, b ? 2'b10 : 2'b01, b, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] d);
      for (int k = 0; k < 8; k++) send_bit(d[k]);
   endtask

   task automatic send_sync();
      drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic send_eop();
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int s_start, s_stb, s_ok, s_err;
      bit aborted;
      s_start = n_start; s_stb = n_stb; s_ok = n_ok; s_err = n_err;
      aborted = 1'b0;
      send_sync();
      for (int i = 0; i < v.nb && !aborted; i++) begin
         for (int k = 0; k < 8 && !aborted; k++) begin
            if (i == v.bserr && k == 3) begin
               drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
               aborted = 1'b1;
            end else begin
               send_bit(v.b[i][k]);
               if (v.skip != 0 && i == 1 && k == 3)
                  drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            end
         end
      end
      if (!aborted) begin
         for (int k = 0; k < v.extra; k++) send_bit(1'b0);
         send_eop();
      end
      idle(4);
      check($sformatf("v%0d_start", idx), n_start - s_start, v.exp_start);
      check($sformatf("v%0d_pid", idx), int'(pkt_pid), v.exp_pid);
      check($sformatf("v%0d_stb", idx), n_stb - s_stb, v.exp_stb);
      check($sformatf("v%0d_ok", idx), n_ok - s_ok, v.exp_ok);
      check($sformatf("v%0d_err", idx), n_err - s_err, v.exp_err);
      if (v.exp_stb > 0)
         check($sformatf("v%0d_data", idx), int'(pkt_data), v.exp_data);
   endtask

   initial begin
      //              b0     b1     b2     b3   nb ex sk bse  st pid stb ok err data
      vecs[0]  = mk(8'hD2, 8'h00, 8'h00, 8'h00, 1, 0, 0, -1, 1, 2,  0, 1, 0, 0);
      vecs[1]  = mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 0, 0, -1, 1, 13, 2, 1, 0, 8'h10);
      vecs[2]  = mk(8'h2D, 8'h00, 8'h11, 8'h00, 3, 0, 0, -1, 1, 13, 2, 0, 1, 8'h11);
      vecs[3]  = mk(8'hC3, 8'h00, 8'h00, 8'h00, 3, 0, 0, -1, 1, 3,  2, 1, 0, 8'h00);
      vecs[4]  = mk(8'hC3, 8'h00, 8'h01, 8'h00, 3, 0, 0, -1, 1, 3,  2, 0, 1, 8'h01);
      vecs[5]  = mk(8'hD3, 8'h00, 8'h00, 8'h00, 2, 0, 0, -1, 0, 3,  0, 0, 1, 0);
      vecs[6]  = mk(8'hD2, 8'h00, 8'h00, 8'h00, 1, 0, 0, -1, 1, 2,  0, 1, 0, 0);
      vecs[7]  = mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 0, 0,  2, 1, 13, 1, 0, 1, 8'h00);
      vecs[8]  = mk(8'h2D, 8'h00, 8'h00, 8'h00, 1, 4, 0, -1, 1, 13, 0, 0, 1, 0);
      vecs[9]  = mk(8'h2D, 8'h00, 8'h10, 8'h00, 3, 0, 1, -1, 1, 13, 2, 1, 0, 8'h10);
      vecs[10] = mk(8'h69, 8'h00, 8'h10, 8'h00, 3, 0, 0, -1, 1, 9,  2, 1, 0, 8'h10);
      vecs[11] = mk(8'hB4, 8'h00, 8'h10, 8'h00, 3, 0, 0, -1, 1, 4,  2, 1, 0, 8'h10);
      vecs[12] = mk(8'h2D, 8'h00, 8'h10, 8'h00, 4, 0, 0, -1, 1, 13, 3, 0, 1, 8'h00);
      vecs[13] = mk(8'hD2, 8'h00, 8'h00, 8'h00, 2, 0, 0, -1, 1, 2,  1, 0, 1, 8'h00);
      vecs[14] = mk(8'h3C, 8'h00, 8'h00, 8'h00, 1, 0, 0, -1, 1, 12, 0, 1, 0, 0);
      vecs[15] = mk(8'h78, 8'h00, 8'h00, 8'h00, 1, 0, 0, -1, 1, 8,  0, 0, 1, 0);
      vecs[16] = mk(8'hC3, 8'h00, 8'h00, 8'h00, 2, 0, 0, -1, 1, 3,  1, 0, 1, 8'h00);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_start", int'(pkt_start), 0);
      check("rst_pid", int'(pkt_pid), 0);
      check("rst_data", int'(pkt_data), 0);
      check("rst_stb", int'(pkt_data_stb), 0);
      check("rst_ok", int'(pkt_done_ok), 0);
      check("rst_err", int'(pkt_done_err), 0);
      rst = 1'b0;
      idle(2);

      // Output latency and single-cycle pulse width on an ACK
      send_sync();
      send_byte(8'hD2);
      @(posedge clk); #1;
      check("lat_start_hi", int'(pkt_start), 1);
      check("lat_pid", int'(pkt_pid), 2);
      idle(1);
      @(posedge clk); #1;
      check("lat_start_lo", int'(pkt_start), 0);
      send_eop();
      @(posedge clk); #1;
      check("lat_ok_hi", int'(pkt_done_ok), 1);
      idle(1);
      @(posedge clk); #1;
      check("lat_ok_lo", int'(pkt_done_ok), 0);
      idle(2);

      for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

      // Asynchronous reset in the middle of a data packet
      send_sync();
      send_byte(8'h2D);
      send_byte(8'h10);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      @(negedge clk);
      ll_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_pid", int'(pkt_pid), 0);
      check("arst_data", int'(pkt_data), 0);
      check("arst_pulses", int'({pkt_start, pkt_data_stb, pkt_done_ok, pkt_done_err}), 0);
      idle(2);
      rst = 1'b0;
      // Bits without SYNC must be ignored after reset
      send_byte(8'hD2);
      send_eop();
      idle(3);
      run_vec(vecs[0], 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
